// File: rtl/servo_pkg.sv
// +----------------------------------------------------------------------+
// | servo_pkg: constants and state encoding shared by servo encode/decode |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package servo_pkg;

  localparam int DEF_CLK_HZ        = 50000000;
  localparam int DEF_TICK_HZ       = 128000;
  localparam int DEF_MIN_TICKS     = 64;
  localparam int DEF_GLITCH_TICKS  = 8;
  localparam int DEF_TIMEOUT_TICKS = 7680;

  localparam int CODE_W    = 8;
  localparam int WIDTH_W   = 12;
  localparam int TIMEOUT_W = 13;

  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } cap_state_e;

  // Inverse of the controller's encoding: width in ticks minus the code-0 offset, clamped.
  function automatic logic [CODE_W-1:0] width_to_code(input logic [WIDTH_W-1:0] width,
                                                      input logic [WIDTH_W-1:0] min_w);
    logic [WIDTH_W-1:0] diff;
    diff = width - min_w;
    if (width <= min_w) return '0;
    if (diff > WIDTH_W'((1 << CODE_W) - 1)) return '1;
    return diff[CODE_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/pulse_capture_channel.sv
// +----------------------------------------------------------------------+
// | pulse_capture_channel: one servo input -> 8-bit code, fresh, stale    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module pulse_capture_channel
  import servo_pkg::*;
#(
  parameter int min_ticks     = DEF_MIN_TICKS,
  parameter int glitch_ticks  = DEF_GLITCH_TICKS,
  parameter int timeout_ticks = DEF_TIMEOUT_TICKS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_i,
  input  logic              pwm_i,
  input  logic              rd_clr_i,
  output logic [CODE_W-1:0] code_o,
  output logic              fresh_o,
  output logic              stale_o
);

  localparam logic [WIDTH_W-1:0]   c_min_w    = WIDTH_W'(min_ticks);
  localparam logic [WIDTH_W-1:0]   c_glitch_w = WIDTH_W'(glitch_ticks);
  localparam logic [TIMEOUT_W-1:0] c_to_max   = TIMEOUT_W'(timeout_ticks);

  logic [1:0]           sync_q;
  logic                 level_q, rise_q, fall_q;
  cap_state_e           state_q, state_d;
  logic [WIDTH_W-1:0]   width_q, width_d;
  logic [TIMEOUT_W-1:0] to_q, to_d;
  logic [CODE_W-1:0]    code_q, code_d;
  logic                 fresh_q, fresh_d;
  logic                 stale_q, stale_d;
  logic                 accept;

  // Edge events are registered so both edges see identical pin-to-event latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], pwm_i};
      level_q <= sync_q[1];
      rise_q  <= sync_q[1] & ~level_q;
      fall_q  <= ~sync_q[1] & level_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ARM;
      width_q <= '0;
      to_q    <= '0;
      code_q  <= '0;
      fresh_q <= 1'b0;
      stale_q <= 1'b0;
    end else begin
      state_q <= state_d;
      width_q <= width_d;
      to_q    <= to_d;
      code_q  <= code_d;
      fresh_q <= fresh_d;
      stale_q <= stale_d;
    end
  end

  always_comb begin
    state_d = state_q;
    width_d = width_q;
    to_d    = to_q;
    code_d  = code_q;
    fresh_d = fresh_q;
    stale_d = stale_q;
    accept  = 1'b0;

    case (state_q)
      ST_ARM: if (!sync_q[1]) state_d = ST_LOW;
      ST_LOW: begin
        if (rise_q) begin
          width_d = '0;
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (fall_q) begin
          state_d = ST_LOW;
          accept  = (width_q >= c_glitch_w);
        end else if (tick_i && (width_q != '1)) begin
          width_d = width_q + 1'b1;
        end
      end
      default: state_d = ST_ARM;
    endcase

    if (rise_q) to_d = '0;
    else if (tick_i && (to_q != c_to_max)) to_d = to_q + 1'b1;

    if (to_q == c_to_max) stale_d = 1'b1;
    if (rd_clr_i) fresh_d = 1'b0;

    // A capture landing with a read of this channel keeps fresh set.
    if (accept) begin
      code_d  = width_to_code(width_q, c_min_w);
      fresh_d = 1'b1;
      stale_d = 1'b0;
    end
  end

  assign code_o  = code_q;
  assign fresh_o = fresh_q;
  assign stale_o = stale_q;

endmodule

`default_nettype wire

// File: rtl/servo_pulse_decoder.sv
// +----------------------------------------------------------------------+
// | servo_pulse_decoder: N-channel servo pulse-width to 8-bit code reader |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module servo_pulse_decoder
  import servo_pkg::*;
#(
  parameter int n_channels             = 4,
  parameter int nbits                  = $clog2(n_channels),
  parameter int clk_frequency          = DEF_CLK_HZ,
  parameter int required_clk_frequency = DEF_TICK_HZ,
  parameter int min_ticks              = DEF_MIN_TICKS,
  parameter int glitch_ticks           = DEF_GLITCH_TICKS,
  parameter int timeout_ticks          = DEF_TIMEOUT_TICKS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [n_channels-1:0] PwmIn,
  input  logic [nbits-1:0]      address,
  input  logic                  read,
  output logic [CODE_W-1:0]     dutycycle,
  output logic                  valid,
  output logic [n_channels-1:0] fresh,
  output logic [n_channels-1:0] stale
);

  localparam int c_div    = clk_frequency / required_clk_frequency;
  localparam int c_tick_w = (c_div > 1) ? $clog2(c_div) : 1;

  logic [c_tick_w-1:0] tick_cnt_q, tick_cnt_d;
  logic                tick;

  assign tick       = (tick_cnt_q == c_tick_w'(c_div - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt_q <= '0;
    else        tick_cnt_q <= tick_cnt_d;
  end

  logic [n_channels-1:0][CODE_W-1:0] codes;
  logic [n_channels-1:0]             rd_clr;

  for (genvar g = 0; g < n_channels; g++) begin : g_channel
    assign rd_clr[g] = read && (int'(address) == g);

    pulse_capture_channel #(
      .min_ticks     (min_ticks),
      .glitch_ticks  (glitch_ticks),
      .timeout_ticks (timeout_ticks)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick_i   (tick),
      .pwm_i    (PwmIn[g]),
      .rd_clr_i (rd_clr[g]),
      .code_o   (codes[g]),
      .fresh_o  (fresh[g]),
      .stale_o  (stale[g])
    );
  end

  logic [CODE_W-1:0] sel_code;
  logic [CODE_W-1:0] dutycycle_q, dutycycle_d;
  logic              valid_q;

  // Out-of-range addresses match no channel and read back as zero.
  always_comb begin
    sel_code = '0;
    for (int i = 0; i < n_channels; i++) begin
      if (int'(address) == i) sel_code = codes[i];
    end
    dutycycle_d = read ? sel_code : dutycycle_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dutycycle_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      dutycycle_q <= dutycycle_d;
      valid_q     <= read;
    end
  end

  assign dutycycle = dutycycle_q;
  assign valid     = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_servo_pulse_decoder.sv
// +----------------------------------------------------------------------+
// | tb_servo_pulse_decoder: randomized self-checking bench for the decoder|
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_servo_pulse_decoder;

  localparam int N       = 4;
  localparam int NB      = 3;
  localparam int DIV     = 3;
  localparam int MIN     = 64;
  localparam int GLITCH  = 8;
  localparam int TIMEOUT = 7680;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  PwmIn;
  logic [NB-1:0] address;
  logic          read;
  logic [7:0]    dutycycle;
  logic          valid;
  logic [N-1:0]  fresh;
  logic [N-1:0]  stale;

  int checks = 0;
  int errors = 0;

  // Reference model: acceptable code window per channel and expected fresh flags.
  int exp_lo[N];
  int exp_hi[N];
  bit exp_fresh[N];

  servo_pulse_decoder #(
    .n_channels             (N),
    .nbits                  (NB),
    .clk_frequency          (128000 * DIV),
    .required_clk_frequency (128000),
    .min_ticks              (MIN),
    .glitch_ticks           (GLITCH),
    .timeout_ticks          (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .PwmIn     (PwmIn),
    .address   (address),
    .read      (read),
    .dutycycle (dutycycle),
    .valid     (valid),
    .fresh     (fresh),
    .stale     (stale)
  );

  always #5 clk = ~clk;

  function automatic int ref_code(input int ticks);
    if (ticks <= MIN) return 0;
    if (ticks - MIN > 255) return 255;
    return ticks - MIN;
  endfunction

  function automatic logic [N-1:0] exp_fresh_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = exp_fresh[i];
    return v;
  endfunction

  function automatic void model_capture(input int ch, input int ticks);
    if (ticks >= GLITCH) begin
      exp_lo[ch]    = ref_code(ticks - 1);
      exp_hi[ch]    = ref_code(ticks + 1);
      exp_fresh[ch] = 1'b1;
    end
  endfunction

  task automatic do_read(input int a, output logic [7:0] dc, output logic v);
    @(negedge clk);
    address = a[NB-1:0];
    read    = 1'b1;
    @(negedge clk);
    read = 1'b0;
    dc   = dutycycle;
    v    = valid;
    if (a < N) exp_fresh[a] = 1'b0;
  endtask

  // h[i] = pulse width in ticks on channel i, 0 = no pulse.
  task automatic drive_pulses(input int h[N]);
    int maxh;
    maxh = 0;
    for (int i = 0; i < N; i++) if (h[i] > maxh) maxh = h[i];
    @(negedge clk);
    for (int i = 0; i < N; i++) if (h[i] > 0) PwmIn[i] = 1'b1;
    for (int c = 1; c <= maxh * DIV; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (h[i] * DIV == c) PwmIn[i] = 1'b0;
    end
    repeat (8) @(negedge clk);
    for (int i = 0; i < N; i++) if (h[i] > 0) model_capture(i, h[i]);
  endtask

  task automatic test_reset();
    logic [7:0] dc;
    logic       v;
    int         h[N];
    rst_n = 1'b0; read = 1'b0; address = '0; PwmIn = '0;
    for (int i = 0; i < N; i++) begin exp_lo[i] = 0; exp_hi[i] = 0; exp_fresh[i] = 1'b0; end
    repeat (12) begin @(negedge clk); PwmIn = N'($urandom); end
    checks++; if (dutycycle !== 8'd0) begin errors++; $display("FAIL reset_dutycycle got %0d want 0", dutycycle); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (fresh !== '0) begin errors++; $display("FAIL reset_fresh got %b want 0000", fresh); end
    checks++; if (stale !== '0) begin errors++; $display("FAIL reset_stale got %b want 0000", stale); end
    PwmIn = 4'b0001;
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(negedge clk);
    PwmIn = '0;
    repeat (10) @(negedge clk);
    checks++; if (fresh !== '0) begin errors++; $display("FAIL reset_inflight_pulse fresh got %b want 0000", fresh); end
    h = '{100, 0, 0, 0};
    drive_pulses(h);
    checks++; if (fresh !== exp_fresh_vec()) begin errors++; $display("FAIL reset_first_capture fresh got %b want %b", fresh, exp_fresh_vec()); end
    do_read(0, dc, v);
    checks++; if (v !== 1'b1 || int'(dc) < exp_lo[0] || int'(dc) > exp_hi[0])
      begin errors++; $display("FAIL reset_first_read got valid=%b code=%0d want valid=1 code %0d..%0d", v, dc, exp_lo[0], exp_hi[0]); end
  endtask

  task automatic test_nominal();
    logic [7:0] dc;
    logic       v;
    int         h[N];
    h = '{0, 192, 0, 0};
    drive_pulses(h);
    checks++; if (fresh[1] !== 1'b1) begin errors++; $display("FAIL nominal_fresh got %b want 1", fresh[1]); end
    do_read(1, dc, v);
    checks++; if (v !== 1'b1 || int'(dc) < exp_lo[1] || int'(dc) > exp_hi[1])
      begin errors++; $display("FAIL nominal_read got valid=%b code=%0d want valid=1 code %0d..%0d", v, dc, exp_lo[1], exp_hi[1]); end
    checks++; if (fresh[1] !== 1'b0) begin errors++; $display("FAIL nominal_fresh_clear got %b want 0", fresh[1]); end
  endtask

  task automatic test_clamp();
    logic [7:0] dc;
    logic       v;
    int         h[N];
    h = '{0, 0, 0, 40};
    drive_pulses(h);
    do_read(3, dc, v);
    checks++; if (dc !== 8'd0) begin errors++; $display("FAIL clamp_low got %0d want 0", dc); end
    h = '{0, 0, 0, 400};
    drive_pulses(h);
    do_read(3, dc, v);
    checks++; if (dc !== 8'd255) begin errors++; $display("FAIL clamp_high got %0d want 255", dc); end
    h = '{0, 0, 0, 3};
    drive_pulses(h);
    checks++; if (fresh[3] !== 1'b0) begin errors++; $display("FAIL glitch_fresh got %b want 0", fresh[3]); end
    do_read(3, dc, v);
    checks++; if (dc !== 8'd255) begin errors++; $display("FAIL glitch_code got %0d want 255", dc); end
  endtask

  task automatic test_timeout();
    logic [7:0] dc;
    logic       v;
    int         c;
    int         h[N];
    @(negedge clk);
    PwmIn[2] = 1'b1;
    c = 0;
    repeat (114 * DIV) begin @(negedge clk); c++; end
    PwmIn[2] = 1'b0;
    repeat (8) begin @(negedge clk); c++; end
    model_capture(2, 114);
    do_read(2, dc, v);
    c += 2;
    checks++; if (int'(dc) < exp_lo[2] || int'(dc) > exp_hi[2])
      begin errors++; $display("FAIL timeout_setup_code got %0d want %0d..%0d", dc, exp_lo[2], exp_hi[2]); end
    while (c < (TIMEOUT - 2) * DIV) begin @(negedge clk); c++; end
    checks++; if (stale[2] !== 1'b0) begin errors++; $display("FAIL timeout_early got stale=%b want 0 at cycle %0d", stale[2], c); end
    while (stale[2] !== 1'b1 && c < (TIMEOUT + 3) * DIV) begin @(negedge clk); c++; end
    checks++; if (stale[2] !== 1'b1) begin errors++; $display("FAIL timeout_stale got %b want 1 within %0d cycles", stale[2], c); end
    do_read(2, dc, v);
    checks++; if (int'(dc) < exp_lo[2] || int'(dc) > exp_hi[2])
      begin errors++; $display("FAIL timeout_code_kept got %0d want %0d..%0d", dc, exp_lo[2], exp_hi[2]); end
    h = '{0, 0, 100, 0};
    drive_pulses(h);
    checks++; if (stale[2] !== 1'b0) begin errors++; $display("FAIL timeout_recover got stale=%b want 0", stale[2]); end
    do_read(2, dc, v);
    checks++; if (int'(dc) < exp_lo[2] || int'(dc) > exp_hi[2])
      begin errors++; $display("FAIL timeout_new_code got %0d want %0d..%0d", dc, exp_lo[2], exp_hi[2]); end
  endtask

  task automatic test_collision();
    logic [7:0] dc;
    logic       v;
    int         old_lo, old_hi;
    old_lo = exp_lo[0];
    old_hi = exp_hi[0];
    @(negedge clk);
    PwmIn[0] = 1'b1;
    repeat (150 * DIV) @(negedge clk);
    PwmIn[0] = 1'b0;
    // Pin fall reaches the capture register on the fourth rising edge.
    repeat (3) @(negedge clk);
    address = '0;
    read    = 1'b1;
    @(negedge clk);
    read = 1'b0;
    checks++; if (valid !== 1'b1 || int'(dutycycle) < old_lo || int'(dutycycle) > old_hi)
      begin errors++; $display("FAIL collision_old_code got valid=%b code=%0d want valid=1 code %0d..%0d", valid, dutycycle, old_lo, old_hi); end
    model_capture(0, 150);
    checks++; if (fresh[0] !== 1'b1) begin errors++; $display("FAIL collision_fresh got %b want 1", fresh[0]); end
    do_read(0, dc, v);
    checks++; if (int'(dc) < exp_lo[0] || int'(dc) > exp_hi[0])
      begin errors++; $display("FAIL collision_new_code got %0d want %0d..%0d", dc, exp_lo[0], exp_hi[0]); end
    exp_fresh[3] = 1'b0;
    do_read(3, dc, v);
    drive_pulses('{0, 0, 0, 90});
    do_read(7, dc, v);
    checks++; if (v !== 1'b1 || dc !== 8'd0) begin errors++; $display("FAIL bad_address got valid=%b code=%0d want valid=1 code=0", v, dc); end
    checks++; if (fresh !== exp_fresh_vec()) begin errors++; $display("FAIL bad_address_flags got fresh=%b want %b", fresh, exp_fresh_vec()); end
  endtask

  task automatic read_all_back_to_back(input string tag);
    @(negedge clk);
    address = '0;
    read    = 1'b1;
    for (int a = 0; a < N; a++) begin
      @(negedge clk);
      if (a < N - 1) address = NB'(a + 1);
      else           read = 1'b0;
      checks++; if (valid !== 1'b1 || int'(dutycycle) < exp_lo[a] || int'(dutycycle) > exp_hi[a])
        begin errors++; $display("FAIL %s ch%0d got valid=%b code=%0d want valid=1 code %0d..%0d", tag, a, valid, dutycycle, exp_lo[a], exp_hi[a]); end
      exp_fresh[a] = 1'b0;
    end
    @(negedge clk);
    checks++; if (valid !== 1'b0 || int'(dutycycle) < exp_lo[N-1] || int'(dutycycle) > exp_hi[N-1])
      begin errors++; $display("FAIL %s hold got valid=%b code=%0d want valid=0 code %0d..%0d", tag, valid, dutycycle, exp_lo[N-1], exp_hi[N-1]); end
    checks++; if (fresh !== exp_fresh_vec()) begin errors++; $display("FAIL %s fresh got %b want %b", tag, fresh, exp_fresh_vec()); end
  endtask

  task automatic test_loopback();
    int h[N];
    h = '{MIN + 0, MIN + 1, MIN + 127, MIN + 255};
    drive_pulses(h);
    read_all_back_to_back("loopback");
  endtask

  task automatic test_random();
    int h[N];
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) h[i] = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(10, 400));
      drive_pulses(h);
      checks++; if (fresh !== exp_fresh_vec()) begin errors++; $display("FAIL random_fresh round %0d got %b want %b", r, fresh, exp_fresh_vec()); end
      read_all_back_to_back("random");
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_clamp();
    test_timeout();
    test_collision();
    test_loopback();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
